adc_lane_word_aligner: RTL and testbench

Recovers word boundaries on one 6-bit ADC deserializer lane in the DSP clock domain. Sits directly downstream of the analog top's per-lane `odat_deser*` outputs, one instance per lane. During training it sweeps a bit-slip offset until a known pattern is seen repeatedly. Once locked, it delivers aligned 6-bit samples to the DSP datapath with a valid flag.

---
 rtl/adc_lane_word_aligner.sv | 196 +++++++++++++++++++
 tb/tb_adc_lane_word_aligner.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_lane_word_aligner.sv
// adc_lane_word_aligner: recovers 6-bit word boundaries on one ADC deserializer
// lane. During training it sweeps a bit-slip offset until TRAIN_PATTERN is seen
// LOCK_COUNT times in a row, then streams aligned words with a valid flag.
// Optional feature: define ADC_ALIGN_ERRCNT_EN to add the 16-bit oerrcnt output
// that counts pattern errors seen while locked.
module adc_lane_word_aligner #(
    parameter logic [5:0] TRAIN_PATTERN = 6'b000111,
    parameter int         LOCK_COUNT    = 8,
    parameter int         SETTLE        = 2,
    parameter int         MAX_SWEEPS    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        relock,
    input  logic        itrain,
    input  logic [5:0]  idat,
    output logic [5:0]  odat,
    output logic        ovalid,
    output logic        olocked,
    output logic        ofail,
`ifdef ADC_ALIGN_ERRCNT_EN
    output logic [15:0] oerrcnt,
`endif
    output logic [2:0]  oslip
);

    localparam logic [7:0] LOCK_LIM   = 8'(LOCK_COUNT);
    localparam logic [3:0] SWEEP_LIM  = 4'(MAX_SWEEPS);
    localparam logic [3:0] SETTLE_LIM = 4'(SETTLE);

    typedef enum logic [2:0] {
        IDLE,
        SEARCH,
        SETTLE_W,
        CHECK,
        LOCKED,
        FAIL
    } state_t;

    state_t      state, state_d;
    logic [5:0]  d_q, d_qq;
    logic [11:0] cat, cat_sh;
    logic [5:0]  aligned;
    logic        is_match;
    logic [2:0]  slip_d;
    logic [7:0]  match_cnt, match_d;
    logic [3:0]  sweep_cnt, sweep_d, sweep_inc;
    logic [2:0]  settle_cnt, settle_d;
    logic        do_slip;
    logic        out_en;

    // Newest word sits in the upper half; the slip offset picks a 6-bit window
    // that borrows the low bits from the previous word.
    assign cat      = {d_q, d_qq};
    assign cat_sh   = cat >> (4'd6 - {1'b0, oslip});
    assign aligned  = cat_sh[5:0];
    assign is_match = (aligned == TRAIN_PATTERN);
    assign out_en   = en && !relock;
    assign sweep_inc = (sweep_cnt == 4'hF) ? sweep_cnt : sweep_cnt + 4'd1;

    // Two-word input history; keeps shifting regardless of FSM state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q  <= '0;
            d_qq <= '0;
        end else begin
            d_q  <= idat;
            d_qq <= d_q;
        end
    end

    // FSM state, slip offset and training counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            oslip      <= '0;
            match_cnt  <= '0;
            sweep_cnt  <= '0;
            settle_cnt <= '0;
        end else begin
            state      <= state_d;
            oslip      <= slip_d;
            match_cnt  <= match_d;
            sweep_cnt  <= sweep_d;
            settle_cnt <= settle_d;
        end
    end

    // Next-state logic: en=0 beats relock, relock beats normal training flow.
    always_comb begin
        state_d  = state;
        slip_d   = oslip;
        match_d  = match_cnt;
        sweep_d  = sweep_cnt;
        settle_d = settle_cnt;
        do_slip  = 1'b0;

        if (!en) begin
            state_d  = IDLE;
            slip_d   = '0;
            match_d  = '0;
            sweep_d  = '0;
            settle_d = '0;
        end else if (relock) begin
            state_d  = SEARCH;
            slip_d   = '0;
            match_d  = '0;
            sweep_d  = '0;
            settle_d = '0;
        end else begin
            case (state)
                IDLE: state_d = SEARCH;
                SEARCH: begin
                    if (itrain) begin
                        if (is_match) begin
                            match_d = 8'd1;
                            state_d = (LOCK_LIM <= 8'd1) ? LOCKED : CHECK;
                        end else begin
                            do_slip = 1'b1;
                        end
                    end
                end
                SETTLE_W: begin
                    if ({1'b0, settle_cnt} + 4'd1 >= SETTLE_LIM) begin
                        state_d  = SEARCH;
                        settle_d = '0;
                    end else begin
                        settle_d = settle_cnt + 3'd1;
                    end
                end
                CHECK: begin
                    if (!itrain) begin
                        state_d = SEARCH;
                        match_d = '0;
                    end else if (is_match) begin
                        match_d = (match_cnt >= LOCK_LIM) ? match_cnt : match_cnt + 8'd1;
                        if (match_cnt >= LOCK_LIM - 8'd1) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        do_slip = 1'b1;
                    end
                end
                default: state_d = state;
            endcase

            // A failed compare moves to the next offset; a wrap closes a sweep.
            if (do_slip) begin
                match_d  = '0;
                settle_d = '0;
                state_d  = (SETTLE_LIM == 4'd0) ? SEARCH : SETTLE_W;
                if (oslip == 3'd5) begin
                    slip_d  = '0;
                    sweep_d = sweep_inc;
                    if (sweep_inc >= SWEEP_LIM) begin
                        state_d = FAIL;
                    end
                end else begin
                    slip_d = oslip + 3'd1;
                end
            end
        end
    end

    // Registered status flags and aligned data; flags drop as soon as en or relock act.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            odat    <= '0;
            ovalid  <= 1'b0;
            olocked <= 1'b0;
            ofail   <= 1'b0;
        end else begin
            olocked <= out_en && (state == LOCKED);
            ovalid  <= out_en && (state == LOCKED);
            ofail   <= out_en && (state == FAIL);
            if (out_en && (state == LOCKED)) begin
                odat <= aligned;
            end
        end
    end

`ifdef ADC_ALIGN_ERRCNT_EN
    // Saturating count of training-pattern errors observed while locked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oerrcnt <= '0;
        end else if (relock) begin
            oerrcnt <= '0;
        end else if (en && (state == LOCKED) && itrain && !is_match && (oerrcnt != 16'hFFFF)) begin
            oerrcnt <= oerrcnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_adc_lane_word_aligner.sv
// Bench for adc_lane_word_aligner: directed scenarios plus randomized traffic,
// compared every cycle against a bit-stream reference model.
module tb_adc_lane_word_aligner;

    localparam int         LOCK_COUNT = 8;
    localparam int         SETTLE     = 2;
    localparam int         MAX_SWEEPS = 4;
    localparam logic [5:0] PAT        = 6'b000111;

    localparam int S_IDLE = 0, S_SEARCH = 1, S_SETTLE = 2, S_CHECK = 3, S_LOCKED = 4, S_FAIL = 5;

    logic       clk = 1'b0;
    logic       rst, en, relock, itrain;
    logic [5:0] idat, odat;
    logic       ovalid, olocked, ofail;
    logic [2:0] oslip;
`ifdef ADC_ALIGN_ERRCNT_EN
    logic [15:0] oerrcnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int m_st, m_slip, m_match, m_sweep, m_settle, m_odat, m_err, h0, h1;
    bit m_ovalid, m_olocked, m_ofail;

    adc_lane_word_aligner #(
        .TRAIN_PATTERN(PAT),
        .LOCK_COUNT(LOCK_COUNT),
        .SETTLE(SETTLE),
        .MAX_SWEEPS(MAX_SWEEPS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .relock(relock),
        .itrain(itrain),
        .idat(idat),
        .odat(odat),
        .ovalid(ovalid),
        .olocked(olocked),
        .ofail(ofail),
`ifdef ADC_ALIGN_ERRCNT_EN
        .oerrcnt(oerrcnt),
`endif
        .oslip(oslip)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rotr6(input int w, input int r);
        return ((w >> r) | (w << (6 - r))) & 63;
    endfunction

    task automatic model_reset();
        m_st = S_IDLE; m_slip = 0; m_match = 0; m_sweep = 0; m_settle = 0;
        m_odat = 0; m_err = 0; h0 = 0; h1 = 0;
        m_ovalid = 0; m_olocked = 0; m_ofail = 0;
    endtask

    // Move to the next bit offset; a full lap of six offsets costs one sweep.
    task automatic model_slip();
        m_match = 0;
        m_settle = 0;
        if (m_slip == 5) begin
            m_slip = 0;
            m_sweep++;
            if (m_sweep >= MAX_SWEEPS) begin
                m_st = S_FAIL;
                return;
            end
        end else begin
            m_slip++;
        end
        m_st = (SETTLE == 0) ? S_SEARCH : S_SETTLE;
    endtask

    // One clock edge of the reference, using the inputs present before the edge.
    task automatic model_step();
        int  a;
        bit  hit, on;
        // window of 6 bits taken from the 12-bit history, newest word on top
        a   = ((h0 * 64 + h1) >> (6 - m_slip)) & 63;
        hit = (a == int'(PAT));
        on  = en && !relock;
        m_olocked = on && (m_st == S_LOCKED);
        m_ovalid  = m_olocked;
        m_ofail   = on && (m_st == S_FAIL);
        if (m_olocked) m_odat = a;
        if (relock) m_err = 0;
        else if (en && m_st == S_LOCKED && itrain && !hit && m_err < 65535) m_err++;

        if (!en) begin
            m_st = S_IDLE; m_slip = 0; m_match = 0; m_sweep = 0; m_settle = 0;
        end else if (relock) begin
            m_st = S_SEARCH; m_slip = 0; m_match = 0; m_sweep = 0; m_settle = 0;
        end else begin
            case (m_st)
                S_IDLE: m_st = S_SEARCH;
                S_SEARCH: if (itrain) begin
                    if (hit) begin
                        m_match = 1;
                        m_st = (LOCK_COUNT <= 1) ? S_LOCKED : S_CHECK;
                    end else model_slip();
                end
                S_SETTLE: begin
                    m_settle++;
                    if (m_settle >= SETTLE) begin
                        m_st = S_SEARCH;
                        m_settle = 0;
                    end
                end
                S_CHECK: begin
                    if (!itrain) begin
                        m_st = S_SEARCH;
                        m_match = 0;
                    end else if (hit) begin
                        m_match++;
                        if (m_match >= LOCK_COUNT) m_st = S_LOCKED;
                    end else model_slip();
                end
                default: ;
            endcase
        end
        h1 = h0;
        h0 = int'(idat);
    endtask

    task automatic cmp_all();
        chk("odat", odat, m_odat);
        chk("ovalid", ovalid, m_ovalid);
        chk("olocked", olocked, m_olocked);
        chk("ofail", ofail, m_ofail);
        chk("oslip", oslip, m_slip);
`ifdef ADC_ALIGN_ERRCNT_EN
        chk("oerrcnt", oerrcnt, m_err);
`endif
    endtask

    // One clock: step the model on the rising edge, compare on the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cmp_all();
    endtask

    task automatic drive(input logic e, input logic r, input logic t, input logic [5:0] d);
        en = e; relock = r; itrain = t; idat = d;
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_odat", odat, 0);
        chk("rst_ovalid", ovalid, 0);
        chk("rst_olocked", olocked, 0);
        chk("rst_ofail", ofail, 0);
        chk("rst_oslip", oslip, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit seen_valid;
        rst = 1'b1;
        drive(0, 0, 0, 6'd0);
        repeat (2) @(negedge clk);
        chk("reset_odat", odat, 0);
        chk("reset_ovalid", ovalid, 0);
        chk("reset_olocked", olocked, 0);
        chk("reset_ofail", ofail, 0);
        chk("reset_oslip", oslip, 0);
        model_reset();
        rst = 1'b0;

        // aligned lane: lock expected 10 cycles after en rises
        drive(1, 0, 1, PAT);
        repeat (9) cyc();
        chk("al_not_yet", olocked, 0);
        cyc();
        chk("al_locked", olocked, 1);
        chk("al_valid", ovalid, 1);
        chk("al_slip", oslip, 0);
        chk("al_odat", odat, PAT);

        // rotated lane: needs offset 3, then a pre-rotated 101010 comes out aligned
        drive(1, 1, 1, 6'(rotr6(PAT, 3)));
        cyc();
        relock = 1'b0;
        for (int i = 0; i < 200 && !olocked; i++) cyc();
        chk("rot_locked", olocked, 1);
        chk("rot_slip", oslip, 3);
        idat = 6'(rotr6(6'b101010, 3));
        cyc();
        cyc();
        idat = 6'(rotr6(PAT, 3));
        cyc();
        chk("rot_odat", odat, 6'b101010);
        chk("rot_valid", ovalid, 1);
`ifdef ADC_ALIGN_ERRCNT_EN
        // error counter: three isolated corrupted words at offset 0 while locked
        drive(1, 1, 1, PAT);
        cyc();
        relock = 1'b0;
        for (int i = 0; i < 200 && !olocked; i++) cyc();
        for (int k = 0; k < 3; k++) begin
            idat = 6'b000000;
            cyc();
            idat = PAT;
            repeat (2) cyc();
        end
        cyc();
        chk("err_cnt", oerrcnt, 3);
        chk("err_locked", olocked, 1);
`endif

        // no pattern: fail after 4 sweeps, valid never rises
        drive(1, 1, 1, 6'b111111);
        cyc();
        relock = 1'b0;
        seen_valid = 0;
        for (int i = 0; i < 300 && !ofail; i++) begin
            cyc();
            if (ovalid) seen_valid = 1;
        end
        chk("np_fail", ofail, 1);
        chk("np_valid_seen", seen_valid, 0);
        relock = 1'b1;
        cyc();
        relock = 1'b0;
        chk("np_relock_fail", ofail, 0);
        chk("np_relock_slip", oslip, 0);

        // broken run: 5th compare mismatches, forcing a slip and a fresh count
        drive(1, 1, 1, PAT);
        cyc();
        relock = 1'b0;
        repeat (3) cyc();
        idat = 6'b101101;
        cyc();
        idat = PAT;
        cyc();
        chk("br_slip", oslip, 1);
        chk("br_unlocked", olocked, 0);
        for (int i = 0; i < 200 && !olocked; i++) cyc();
        chk("br_locked", olocked, 1);
        chk("br_slip0", oslip, 0);

        // disturbances: async reset while locked, then en=0 during SETTLE_W
        drive(0, 0, 1, PAT);
        async_reset();
        drive(1, 0, 1, 6'(rotr6(PAT, 3)));
        cyc();
        cyc();
        chk("dis_settle_slip", oslip, 1);
        en = 1'b0;
        cyc();
        chk("dis_idle_slip", oslip, 0);
        en = 1'b1;
        cyc();
        chk("dis_search_slip", oslip, 0);
        for (int i = 0; i < 200 && !olocked; i++) cyc();
        chk("dis_relocked", olocked, 1);
        chk("dis_relock_slip", oslip, 3);

        // randomized traffic: random rotation, corruption, training gaps, en drops, relocks
        for (int it = 0; it < 6; it++) begin
            int rot;
            rot = $urandom_range(0, 5);
            drive(1, 1, 1, 6'(rotr6(PAT, rot)));
            cyc();
            for (int c = 0; c < 250; c++) begin
                en     = ($urandom_range(0, 99) != 0);
                relock = ($urandom_range(0, 149) == 0);
                itrain = ($urandom_range(0, 19) != 0);
                if (itrain && $urandom_range(0, 29) != 0) idat = 6'(rotr6(PAT, rot));
                else idat = 6'($urandom_range(0, 63));
                cyc();
            end
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
